// File: rtl/fmap_pkg.sv
// Shared constants, width helpers and the bank-ownership state type for the
// ping-pong feature-map buffer.
package fmap_pkg;

  localparam int unsigned FmapDw      = 16;
  localparam int unsigned FmapWrLanes = 64;
  localparam int unsigned FmapRdLanes = 16;
  localparam int unsigned FmapDepth   = 4096;

  function automatic int unsigned fmap_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wide enough that base + lane * stride (or base + word) never wraps.
  function automatic int unsigned fmap_ext_w(input int unsigned depth, input int unsigned lanes);
    return fmap_aw(depth) + $clog2(lanes) + 1;
  endfunction

  typedef struct packed {
    logic [1:0] full;
    logic       fill;
    logic       drain;
  } bank_own_t;

endpackage

// File: rtl/fmap_bank.sv
// One feature-map bank: WrLanes-wide strided scatter write and RdLanes-wide
// contiguous gather read, with out-of-range lanes/words masked and flagged.
module fmap_bank
  import fmap_pkg::*;
#(
  parameter int unsigned DW      = FmapDw,
  parameter int unsigned WrLanes = FmapWrLanes,
  parameter int unsigned RdLanes = FmapRdLanes,
  parameter int unsigned Depth   = FmapDepth,
  localparam int unsigned AW     = fmap_aw(Depth)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           wr_base_i,
  input  logic [AW-1:0]           wr_stride_i,
  input  logic [WrLanes*DW-1:0]   wr_data_i,
  output logic                    wr_oob_o,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [RdLanes*DW-1:0]   rd_data_o,
  output logic                    rd_oob_o
);

  localparam int unsigned WrEw = fmap_ext_w(Depth, WrLanes);
  localparam int unsigned RdEw = fmap_ext_w(Depth, RdLanes);

  logic [DW-1:0]      mem_q [Depth];
  logic [WrEw-1:0]    lane_addr [WrLanes];
  logic [WrLanes-1:0] lane_ok;
  logic [RdEw-1:0]    word_addr [RdLanes];
  logic [RdLanes-1:0] word_ok;

  always_comb begin
    for (int unsigned i = 0; i < WrLanes; i++) begin
      lane_addr[i] = WrEw'(wr_base_i) + WrEw'(i) * WrEw'(wr_stride_i);
      lane_ok[i]   = lane_addr[i] < WrEw'(Depth);
    end
    for (int unsigned j = 0; j < RdLanes; j++) begin
      word_addr[j] = RdEw'(rd_addr_i) + RdEw'(j);
      word_ok[j]   = word_addr[j] < RdEw'(Depth);
    end
  end

  assign wr_oob_o = ~&lane_ok;
  assign rd_oob_o = ~&word_ok;

  // Later lanes are scheduled last, so the highest colliding lane wins.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < WrLanes; i++) begin
        if (lane_ok[i]) begin
          mem_q[lane_addr[i][AW-1:0]] <= wr_data_i[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned j = 0; j < RdLanes; j++) begin
      if (word_ok[j]) begin
        rd_data_o[j*DW +: DW] = mem_q[word_addr[j][AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fmap_pingpong_buf.sv
// Double-buffered feature-map store: writer fills one bank while the reader
// drains the other; per-bank full flags hand the banks back and forth.
module fmap_pingpong_buf
  import fmap_pkg::*;
#(
  parameter int unsigned DW      = FmapDw,
  parameter int unsigned WrLanes = FmapWrLanes,
  parameter int unsigned RdLanes = FmapRdLanes,
  parameter int unsigned Depth   = FmapDepth,
  localparam int unsigned AW     = fmap_aw(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [AW-1:0]         wr_base_i,
  input  logic [AW-1:0]         wr_stride_i,
  input  logic [WrLanes*DW-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic                  rd_last_i,
  output logic                  rd_dvalid_o,
  output logic [RdLanes*DW-1:0] rd_data_o,
  output logic                  fill_bank_o,
  output logic                  drain_bank_o,
  output logic [1:0]            bank_full_o,
  output logic                  err_oob_o
);

  bank_own_t             own_q, own_d;
  logic                  rd_dvalid_q, rd_dvalid_d;
  logic [RdLanes*DW-1:0] rd_data_q, rd_data_d;
  logic                  err_oob_q, err_oob_d;

  logic                  wr_acc, rd_acc;
  logic [1:0]            bank_we, bank_wr_oob, bank_rd_oob;
  logic [RdLanes*DW-1:0] bank_rd_data [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(
      .DW      (DW),
      .WrLanes (WrLanes),
      .RdLanes (RdLanes),
      .Depth   (Depth)
    ) u_bank (
      .clk_i       (clk_i),
      .we_i        (bank_we[b]),
      .wr_base_i   (wr_base_i),
      .wr_stride_i (wr_stride_i),
      .wr_data_i   (wr_data_i),
      .wr_oob_o    (bank_wr_oob[b]),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (bank_rd_data[b]),
      .rd_oob_o    (bank_rd_oob[b])
    );
  end

  assign wr_ready_o   = ~own_q.full[own_q.fill];
  assign rd_ready_o   = own_q.full[own_q.drain];
  assign wr_acc       = wr_valid_i & wr_ready_o;
  assign rd_acc       = rd_valid_i & rd_ready_o;
  assign rd_dvalid_o  = rd_dvalid_q;
  assign rd_data_o    = rd_data_q;
  assign fill_bank_o  = own_q.fill;
  assign drain_bank_o = own_q.drain;
  assign bank_full_o  = own_q.full;
  assign err_oob_o    = err_oob_q;

  // When both sides accept, fill and drain necessarily point at different banks.
  always_comb begin
    own_d                = own_q;
    bank_we              = '0;
    bank_we[own_q.fill]  = wr_acc;
    if (wr_acc && wr_last_i) begin
      own_d.full[own_q.fill] = 1'b1;
      own_d.fill             = ~own_q.fill;
    end
    if (rd_acc && rd_last_i) begin
      own_d.full[own_q.drain] = 1'b0;
      own_d.drain             = ~own_q.drain;
    end
    rd_dvalid_d = rd_acc;
    rd_data_d   = rd_acc ? bank_rd_data[own_q.drain] : rd_data_q;
    err_oob_d   = err_oob_q | (wr_acc & bank_wr_oob[own_q.fill])
                            | (rd_acc & bank_rd_oob[own_q.drain]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q       <= '0;
      rd_dvalid_q <= 1'b0;
      rd_data_q   <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      own_q       <= own_d;
      rd_dvalid_q <= rd_dvalid_d;
      rd_data_q   <= rd_data_d;
      err_oob_q   <= err_oob_d;
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Self-checking bench for fmap_pingpong_buf: directed scenarios plus random
// traffic against an array-based behavioural model.
module tb_fmap_pingpong_buf;

  localparam int DW = 16, WL = 4, RL = 2, DEPTH = 64, AW = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0, wr_last = 1'b0, rd_valid = 1'b0, rd_last = 1'b0;
  logic [AW-1:0]    wr_base = '0, wr_stride = '0, rd_addr = '0;
  logic [WL*DW-1:0] wr_data = '0;
  logic             wr_ready, rd_ready, rd_dvalid, fill_bank, drain_bank, err_oob;
  logic [RL*DW-1:0] rd_data;
  logic [1:0]       bank_full;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int               m_mem [2][DEPTH];
  bit               m_full [2];
  bit               m_fill, m_drain, m_err, m_dv;
  logic [RL*DW-1:0] m_rd;

  logic [7:0] act_st;
  assign act_st = {wr_ready, rd_ready, fill_bank, drain_bank, bank_full, rd_dvalid, err_oob};

  always #5 clk = ~clk;

  fmap_pingpong_buf #(
    .DW      (DW),
    .WrLanes (WL),
    .RdLanes (RL),
    .Depth   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_base_i    (wr_base),
    .wr_stride_i  (wr_stride),
    .wr_data_i    (wr_data),
    .wr_last_i    (wr_last),
    .rd_valid_i   (rd_valid),
    .rd_ready_o   (rd_ready),
    .rd_addr_i    (rd_addr),
    .rd_last_i    (rd_last),
    .rd_dvalid_o  (rd_dvalid),
    .rd_data_o    (rd_data),
    .fill_bank_o  (fill_bank),
    .drain_bank_o (drain_bank),
    .bank_full_o  (bank_full),
    .err_oob_o    (err_oob)
  );

  function automatic logic [7:0] exp_st();
    return {!m_full[m_fill], m_full[m_drain], m_fill, m_drain, m_full[1], m_full[0], m_dv, m_err};
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_fill = 0; m_drain = 0; m_err = 0; m_dv = 0; m_rd = '0;
  endtask

  // Advance model by the current inputs, then let the DUT take the same edge.
  task automatic tick();
    bit wacc, racc;
    wacc = wr_valid && !m_full[m_fill];
    racc = rd_valid && m_full[m_drain];
    m_dv = racc;
    if (racc) begin
      for (int j = 0; j < RL; j++) begin
        int a;
        a = int'(rd_addr) + j;
        if (a < DEPTH) m_rd[j*DW +: DW] = DW'(m_mem[m_drain][a]);
        else begin
          m_rd[j*DW +: DW] = '0;
          m_err = 1;
        end
      end
    end
    if (wacc) begin
      for (int i = 0; i < WL; i++) begin
        int a;
        a = int'(wr_base) + i * int'(wr_stride);
        if (a < DEPTH) m_mem[m_fill][a] = int'(wr_data[i*DW +: DW]);
        else m_err = 1;
      end
    end
    if (wacc && wr_last) begin m_full[m_fill] = 1; m_fill = !m_fill; end
    if (racc && rd_last) begin m_full[m_drain] = 0; m_drain = !m_drain; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_last = 0; rd_valid = 0; rd_last = 0;
  endtask

  task automatic drive_wr(input int base, input int stride, input logic [WL*DW-1:0] d,
                          input bit last);
    wr_valid = 1; wr_base = AW'(base); wr_stride = AW'(stride); wr_data = d; wr_last = last;
  endtask

  task automatic drive_rd(input int addr, input bit last);
    rd_valid = 1; rd_addr = AW'(addr); rd_last = last;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (act_st !== exp_st() || rd_data !== '0) begin
      n_errors++;
      $display("FAIL reset_state: status %b data %h, required %b data 0", act_st, rd_data,
               exp_st());
    end
    rst_n = 1;
    tick();
    n_checks++;
    if (act_st !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL reset_release: status %b, required 10000000", act_st);
    end
  endtask

  // Writes every word of both banks so no later read can return X.
  task automatic test_fill_all();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 16; k++) begin
        drive_wr(k * 4, 1, {$urandom, $urandom}, k == 15);
        tick();
        n_checks++;
        if (act_st !== exp_st()) begin
          n_errors++;
          $display("FAIL fill_all_wr b%0d k%0d: status %b, required %b", b, k, act_st, exp_st());
        end
      end
    end
    idle();
    tick();
    n_checks++;
    if (wr_ready !== 1'b0 || bank_full !== 2'b11) begin
      n_errors++;
      $display("FAIL both_full: wr_ready %b full %b, required 0 11", wr_ready, bank_full);
    end
    for (int k = 0; k < 32; k++) begin
      drive_rd(2 * k, k == 31);
      tick();
      n_checks++;
      if (act_st !== exp_st() || rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL fill_all_rd k%0d: status %b data %h, required %b data %h", k, act_st,
                 rd_data, exp_st(), m_rd);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midread();
    drive_rd(4, 0);
    tick();
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (rd_dvalid !== 1'b0 || act_st !== exp_st() || rd_data !== '0) begin
      n_errors++;
      $display("FAIL reset_midread: dvalid %b status %b data %h, required 0 %b 0", rd_dvalid,
               act_st, rd_data, exp_st());
    end
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    n_checks++;
    if (rd_dvalid !== 1'b0 || wr_ready !== 1'b1 || rd_ready !== 1'b0 || bank_full !== 2'b00 ||
        fill_bank !== 1'b0 || drain_bank !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_after: status %b, required 10000000", act_st);
    end
  endtask

  task automatic test_strided();
    drive_wr(0, 16, {16'd4, 16'd3, 16'd2, 16'd1}, 1);
    tick();
    idle();
    n_checks++;
    if (bank_full !== 2'b01 || fill_bank !== 1'b1) begin
      n_errors++;
      $display("FAIL strided_full: full %b fill %b, required 01 1", bank_full, fill_bank);
    end
    for (int k = 0; k < 4; k++) begin
      drive_rd(16 * k, k == 3);
      tick();
      idle();
      n_checks++;
      if (rd_dvalid !== 1'b1 || rd_data[DW-1:0] !== DW'(k + 1) || rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL strided_rd%0d: dvalid %b data %h, required 1 word0 %0d data %h", k,
                 rd_dvalid, rd_data, k + 1, m_rd);
      end
    end
    tick();
    n_checks++;
    if (rd_dvalid !== 1'b0 || act_st !== exp_st()) begin
      n_errors++;
      $display("FAIL strided_done: status %b, required %b", act_st, exp_st());
    end
  endtask

  task automatic test_pingpong();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        drive_wr(k * 4, 1, {$urandom, $urandom}, k == 3);
        tick();
      end
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      drive_rd(2 * k, k == 1);
      tick();
    end
    idle();
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_wr(16 + k * 4, 1, {$urandom, $urandom}, k == 3);
      drive_rd($urandom_range(0, 62), k == 3);
      tick();
      n_checks++;
      if (act_st !== exp_st() || rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL overlap k%0d: status %b data %h, required %b data %h", k, act_st, rd_data,
                 exp_st(), m_rd);
      end
    end
    idle();
    n_checks++;
    if (bank_full !== 2'b10 || fill_bank !== 1'b0 || drain_bank !== 1'b1) begin
      n_errors++;
      $display("FAIL overlap_swap: full %b fill %b drain %b, required 10 0 1", bank_full,
               fill_bank, drain_bank);
    end
    for (int k = 0; k < 16; k++) begin
      drive_rd(2 * k, 0);
      tick();
      n_checks++;
      if (rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL overlap_data a%0d: got %h, required %h", 2 * k, rd_data, m_rd);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    drive_wr(0, 1, {$urandom, $urandom}, 1);
    tick();
    idle();
    n_checks++;
    if (wr_ready !== 1'b0 || bank_full !== 2'b11) begin
      n_errors++;
      $display("FAIL bp_full: wr_ready %b full %b, required 0 11", wr_ready, bank_full);
    end
    drive_wr(8, 1, {$urandom, $urandom}, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (wr_ready !== 1'b0 || act_st !== exp_st()) begin
        n_errors++;
        $display("FAIL bp_stall c%0d: status %b, required %b", k, act_st, exp_st());
      end
    end
    idle();
    drive_rd(0, 1);
    tick();
    idle();
    n_checks++;
    if (wr_ready !== 1'b1 || bank_full !== 2'b01) begin
      n_errors++;
      $display("FAIL bp_release: wr_ready %b full %b, required 1 01", wr_ready, bank_full);
    end
    for (int k = 0; k < 2; k++) begin
      drive_rd(8 + 2 * k, k == 1);
      tick();
      n_checks++;
      if (rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL bp_nowrite k%0d: got %h, required %h", k, rd_data, m_rd);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_oob();
    logic [WL*DW-1:0] d;
    d = {$urandom, $urandom};
    n_checks++;
    if (err_oob !== 1'b0) begin
      n_errors++;
      $display("FAIL oob_pre: err_oob %b, required 0", err_oob);
    end
    drive_wr(60, 2, d, 1);
    tick();
    idle();
    n_checks++;
    if (err_oob !== 1'b1 || act_st !== exp_st()) begin
      n_errors++;
      $display("FAIL oob_wr: status %b, required %b", act_st, exp_st());
    end
    drive_rd(60, 0);
    tick();
    n_checks++;
    if (rd_data[DW-1:0] !== d[DW-1:0] || rd_data !== m_rd) begin
      n_errors++;
      $display("FAIL oob_lane0: got %h, required word0 %h data %h", rd_data, d[DW-1:0], m_rd);
    end
    drive_rd(62, 0);
    tick();
    n_checks++;
    if (rd_data[DW-1:0] !== d[2*DW-1:DW]) begin
      n_errors++;
      $display("FAIL oob_lane1: got %h, required %h", rd_data[DW-1:0], d[2*DW-1:DW]);
    end
    drive_rd(63, 1);
    tick();
    idle();
    n_checks++;
    if (rd_data[2*DW-1:DW] !== '0 || rd_data !== m_rd || err_oob !== 1'b1) begin
      n_errors++;
      $display("FAIL oob_rd63: data %h err %b, required %h err 1", rd_data, err_oob, m_rd);
    end
  endtask

  task automatic test_collision();
    drive_wr(5, 0, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1);
    tick();
    idle();
    drive_rd(5, 1);
    tick();
    idle();
    n_checks++;
    if (rd_data[DW-1:0] !== 16'hDDDD || rd_data !== m_rd) begin
      n_errors++;
      $display("FAIL collision: got %h, required word0 dddd data %h", rd_data, m_rd);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_valid  = 1'($urandom);
      wr_base   = AW'($urandom);
      wr_stride = AW'($urandom_range(0, 20));
      wr_data   = {$urandom, $urandom};
      wr_last   = ($urandom_range(0, 3) == 0);
      rd_valid  = 1'($urandom);
      rd_addr   = AW'($urandom);
      rd_last   = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (act_st !== exp_st() || rd_data !== m_rd) begin
        n_errors++;
        $display("FAIL random c%0d: status %b data %h, required %b data %h", c, act_st, rd_data,
                 exp_st(), m_rd);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_all();
    test_reset_midread();
    test_strided();
    test_pingpong();
    test_backpressure();
    test_oob();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
